jk_from_sr: RTL and testbench
=============================

// Module: jk_from_sr
// PURPOSE
//  - JK flip-flop built from an SR flip-flop core plus input steering logic.
//  - Standard clocked JK storage element (hold/set/reset/toggle).
//  - Used as a building block and a teaching reference for flip-flop conversion.
//  - q_bar is always the complement of q.
// PARAMETERS
//  - WIDTH     1   number of independent JK bits (bitwise; bit i uses j[i], k[i], q[i])
//  - RST_VAL   0   value loaded into q on reset (WIDTH bits); q_bar gets ~RST_VAL
// PORTS
//  - clk    in   1      single clock; all state updates on its rising edge
//  - rst    in   1      reset: synchronous, active-high
//  - j      in   WIDTH  J input (set request)
//  - k      in   WIDTH  K input (reset request)
//  - q      out  WIDTH  registered state
//  - q_bar  out  WIDTH  ~q, combinational from q (never a separately stored bit)
// BEHAVIOUR
//  - Steering logic (combinational), per bit:
//    - s = j & ~q
//    - r = k & q
//  - By construction s & r == 0 always; the SR core never sees the illegal 11 input.
//  - SR core, rising clk, per bit:
//    - s=0 r=0 -> hold
//    - s=1 r=0 -> q<=1
//    - s=0 r=1 -> q<=0
//    - s=1 r=1 -> unreachable; resolves to hold
//  - Net JK function at each rising clk when rst=0:
//    - 00 -> hold
//    - 10 -> q<=1
//    - 01 -> q<=0
//    - 11 -> q<=~q
//  - Latency: q reflects j/k one clock edge after they are sampled; no combinational path from j/k to q.
//  - Reset: rst=1 at a rising clk gives q<=RST_VAL and q_bar=~RST_VAL.
//    - Reset overrides j/k in that cycle.
//    - Deasserting rst mid-stream resumes normal JK operation at the next edge.
//  - Before the first reset edge, q is unspecified (X in simulation).
//  - Sustained j=k=1 toggles q every clock edge (divide-by-2).
// CONFIGURATION
//  - Macro JK_FROM_SR_CHECK_EN:
//    - Defined: adds simulation-only checks.
//      - At each rising clk with rst=0, {s,r}==2'b11 on any bit reports $error.
//      - q_bar != ~q reports $error.
//      - Checks are excluded from synthesis (translate_off/ifdef).
//    - Undefined: no checks; the RTL is functionally identical.
// STRUCTURE
//  - Package jk_from_sr_pkg:
//    - localparams for SR input codes SR_HOLD=2'b00, SR_RESET=2'b01, SR_SET=2'b10, SR_ILLEGAL=2'b11.
//    - localparams for JK codes JK_HOLD, JK_RESET, JK_SET, JK_TOGGLE.
//  - Sub-module sr_ff:
//    - parameterized WIDTH and RST_VAL; ports clk, rst, s, r, q.
//    - synchronous active-high reset.
//  - Top level: steering logic, one sr_ff instance, q_bar assignment, optional check block.
// TESTING (10 ns clock, stimulus changes away from the rising edge, WIDTH=1)
//  - rst=1, j=0, k=0 for one edge -> q=0, q_bar=1.
//  - rst=0, j=0, k=0 -> q holds 0 across the edge.
//  - j=1, k=0 -> q=1, q_bar=0 after the next edge.
//  - Then j=0, k=0 -> q stays 1.
//  - Then j=0, k=1 -> q=0 after the next edge.
//  - j=1, k=1 held for 4 edges -> q goes 1,0,1,0.
//  - rst=1 with j=1, k=1 while q=1 -> q=0 at that edge; no toggle.
//  - With JK_FROM_SR_CHECK_EN defined, random j/k for 1000 cycles, with q compared against a JK reference model:
//    - zero $error reports
//    - q matches the model every cycle.

Source files
------------

// File: rtl/jk_from_sr_pkg.sv
// Shared encodings for the JK-from-SR flip-flop: SR core input codes and JK input codes.
// Both are formed as {set_like, reset_like}, i.e. {s,r} and {j,k}.
package jk_from_sr_pkg;

    localparam logic [1:0] SR_HOLD    = 2'b00;
    localparam logic [1:0] SR_RESET   = 2'b01;
    localparam logic [1:0] SR_SET     = 2'b10;
    localparam logic [1:0] SR_ILLEGAL = 2'b11;

    localparam logic [1:0] JK_HOLD    = 2'b00;
    localparam logic [1:0] JK_RESET   = 2'b01;
    localparam logic [1:0] JK_SET     = 2'b10;
    localparam logic [1:0] JK_TOGGLE  = 2'b11;

endpackage

// File: rtl/jk_from_sr_sr_ff.sv
// Bitwise clocked SR flip-flop with synchronous active-high reset.
// The illegal {s,r}=11 code resolves to hold.
module sr_ff
    import jk_from_sr_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({s[i], r[i]})
                    SR_SET:   q[i] <= 1'b1;
                    SR_RESET: q[i] <= 1'b0;
                    default:  q[i] <= q[i];
                endcase
            end
        end
    end

endmodule

// File: rtl/jk_from_sr.sv
// JK flip-flop built from an SR core plus steering logic (s = j & ~q, r = k & q).
// Define JK_FROM_SR_CHECK_EN to add simulation-only consistency checks.
module jk_from_sr
    import jk_from_sr_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;

    // Gating with the current state means s and r can never both be 1,
    // and j=k=1 becomes "set if low, reset if high", i.e. toggle.
    assign s = j & ~q;
    assign r = k & q;

    sr_ff #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_sr_ff (
        .clk (clk),
        .rst (rst),
        .s   (s),
        .r   (r),
        .q   (q)
    );

    assign q_bar = ~q;

`ifdef JK_FROM_SR_CHECK_EN
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ({s[i], r[i]} === SR_ILLEGAL)
                    $error("jk_from_sr: illegal SR input on bit %0d", i);
            end
        end
        if (q_bar !== ~q)
            $error("jk_from_sr: q_bar=%b is not the complement of q=%b", q_bar, q);
    end
`else
    // No checks in this build; behaviour is identical.
`endif

endmodule

// File: tb/tb_jk_from_sr.sv
// Directed and model-checked random test of jk_from_sr (WIDTH=1, RST_VAL=0).
module tb_jk_from_sr;

    localparam int W = 1;

    logic         clk;
    logic         rst;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] q;
    logic [W-1:0] q_bar;

    int checks;
    int failures;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_exp;

    jk_from_sr #(
        .WIDTH   (W),
        .RST_VAL ('0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .j     (j),
        .k     (k),
        .q     (q),
        .q_bar (q_bar)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst = 1'b0;
        j   = '0;
        k   = '0;
    end

    // Scoreboard: pop the expected value for this edge and compare q and q_bar.
    task automatic check_edge(input string tag);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        cur_exp = e;
        checks++;
        assert (q === e) else begin
            failures++;
            $error("FAIL %s q=%b expected=%b", tag, q, e);
        end
        checks++;
        assert (q_bar === ~e) else begin
            failures++;
            $error("FAIL %s_qbar q_bar=%b expected=%b", tag, q_bar, ~e);
        end
    endtask

    // Driver: change inputs on the falling edge, confirm no combinational
    // j/k->q path before the rising edge, then check the registered result.
    task automatic drive(input logic rr, input logic [W-1:0] jj, input logic [W-1:0] kk,
                         input logic [W-1:0] e, input string tag, input bit pre_chk);
        @(negedge clk);
        rst = rr;
        j   = jj;
        k   = kk;
        exp_q.push_back(e);
        if (pre_chk) begin
            #1;
            checks++;
            assert (q === cur_exp) else begin
                failures++;
                $error("FAIL %s_pre q=%b expected=%b", tag, q, cur_exp);
            end
        end
        @(posedge clk);
        #1;
        check_edge(tag);
    endtask

    initial begin
        logic         rr;
        logic [W-1:0] jj;
        logic [W-1:0] kk;
        logic [W-1:0] m;

        checks   = 0;
        failures = 0;
        cur_exp  = 'x;

        // Directed sequence with hand-computed results
        drive(1'b1, 1'b0, 1'b0, 1'b0, "reset",      1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, "hold0",      1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, "set",        1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, "hold1",      1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, "clear",      1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, "toggle1",    1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, "toggle2",    1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, "toggle3",    1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, "toggle4",    1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, "set_again",  1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, "rst_over_jk", 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, "resume",     1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, "clear2",     1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, "clear_hold", 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, "set2",       1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, "set_hold",   1'b1);

        // Random j/k with occasional reset, against a JK truth-table model
        m = cur_exp;
        for (int n = 0; n < 1000; n++) begin
            rr = ($urandom_range(0, 19) == 0);
            jj = W'($urandom_range(0, 1));
            kk = W'($urandom_range(0, 1));
            if (rr)
                m = '0;
            else begin
                case ({jj, kk})
                    2'b10:   m = 1'b1;
                    2'b01:   m = 1'b0;
                    2'b11:   m = ~m;
                    default: m = m;
                endcase
            end
            drive(rr, jj, kk, m, "random", 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
